core_sequencer: RTL

Multi-cycle control FSM for the single-issue RISC-V core. It steps each instruction through fetch, decode, execute, memory and writeback, and runs the instruction- and data-memory request/acknowledge handshakes. It issues the per-cycle write enables and mux selects to the PC, IR, register file and ALU operand/writeback muxes. The ALU operation code stays with the existing combinational decoder; this block owns only sequencing.

---
 rtl/riscv_pkg.sv | 48 ++++
 rtl/instr_class_decode.sv | 35 +++
 rtl/core_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcode, state, class and mux-select encodings for the core
//
// Purpose: constants and types used by the sequencer and the instruction decoders.
// Ports: none (package).
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_AUIPC,
    CLS_LUI,
    CLS_NONE
  } iclass_t;

  localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SEL_IMM   = 2'd1;
  localparam logic [1:0] PC_SEL_ALU   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_IMM  = 2'd3;

endpackage

// File: rtl/instr_class_decode.sv
// rtl/instr_class_decode.sv - combinational opcode to instruction-class decode
//
// Purpose: map IR[6:0] to an instruction class and a legal flag.
// Ports:
//   opcode - IR[6:0]
//   cls    - decoded instruction class (CLS_NONE when unknown)
//   legal  - 1 when opcode is one of the supported classes
module instr_class_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    cls,
  output logic       legal
);

  always_comb begin
    legal = 1'b1;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_I:      cls = CLS_I;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = CLS_JALR;
      OP_AUIPC:  cls = CLS_AUIPC;
      OP_LUI:    cls = CLS_LUI;
      default: begin
        cls   = CLS_NONE;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer for the core
//
// Purpose: steps each instruction through the pipeline states, runs the
// instruction/data memory handshakes and drives datapath enables and selects.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   opcode                - IR[6:0], valid from DECODE
//   branch_taken          - branch comparator result, used in EXEC
//   imem_req / imem_ack   - instruction fetch handshake
//   dmem_req / dmem_we / dmem_ack - data access handshake (we=1 store)
//   ir_we, pc_we, pc_sel  - IR load, PC update and PC source select
//   alu_a_sel, alu_b_sel  - ALU operand selects (a: 0 rs1/1 PC, b: 0 rs2/1 imm)
//   rf_we, wb_sel         - register write enable and writeback source
//   illegal               - sticky unknown-opcode flag
//   retired               - completed-instruction counter
module core_sequencer
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      opcode,
  input  logic            branch_taken,
  output logic            imem_req,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_sel,
  output logic            alu_a_sel,
  output logic            alu_b_sel,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic            illegal,
  output logic [XLEN-1:0] retired
);

  state_t  state;
  iclass_t cls_q;
  iclass_t dec_cls;
  logic    dec_legal;

  instr_class_decode u_decode (
    .opcode (opcode),
    .cls    (dec_cls),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FETCH;
      cls_q   <= CLS_NONE;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      // pc_we fires exactly once per completed instruction, so it doubles
      // as the retire strobe.
      if (pc_we) begin
        retired <= retired + XLEN'(1);
      end
      case (state)
        ST_FETCH: begin
          if (imem_ack) state <= ST_DECODE;
        end
        ST_DECODE: begin
          cls_q <= dec_cls;
          if (!dec_legal) begin
            illegal <= 1'b1;
            state   <= ST_TRAP;
          end else if (dec_cls == CLS_LUI) begin
            state <= ST_WB;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_BRANCH:          state <= ST_FETCH;
            CLS_LOAD, CLS_STORE: state <= ST_MEM;
            default:             state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (dmem_ack) state <= (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
        end
        ST_WB:   state <= ST_FETCH;
        ST_TRAP: state <= ST_TRAP;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Outputs decode the current state; everything is forced low while reset
  // is high so an in-flight access is abandoned without a stray enable.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_SEL_PLUS4;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_SEL_ALU;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_I, CLS_LOAD, CLS_STORE, CLS_JALR: alu_b_sel = 1'b1;
            CLS_AUIPC: begin
              alu_a_sel = 1'b1;
              alu_b_sel = 1'b1;
            end
            CLS_BRANCH: begin
              pc_we  = 1'b1;
              pc_sel = branch_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == CLS_STORE);
          pc_we    = dmem_ack && (cls_q == CLS_STORE);
        end
        ST_WB: begin
          rf_we = 1'b1;
          pc_we = 1'b1;
          case (cls_q)
            CLS_LOAD: wb_sel = WB_SEL_LOAD;
            CLS_JAL: begin
              wb_sel = WB_SEL_PC4;
              pc_sel = PC_SEL_IMM;
            end
            CLS_JALR: begin
              wb_sel = WB_SEL_PC4;
              pc_sel = PC_SEL_ALU;
            end
            CLS_LUI: wb_sel = WB_SEL_IMM;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
